spi_lcd_receiver: RTL

SPI_LCD_RECEIVER -- requirements
Module: spi_lcd_receiver

---
 rtl/spi_lcd_receiver.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_lcd_receiver.sv
// spi_lcd_receiver: SPI (mode 0) slave for an LCD controller command/data stream.
// Oversamples SCLK/MOSI/CS/DC in the i_clk domain, assembles bytes and decodes
// CASET / PASET / RAMWR into windowed RGB565 pixel writes with x/y coordinates.
// Optional feature macro: SPI_LCD_RX_PXCOUNT_EN builds a saturating counter of
// emitted pixels on o_px_count; without it o_px_count is tied to zero.
module spi_lcd_receiver #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_mosi,
  input  logic        i_cs,
  input  logic        i_dc,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte,
  output logic        o_byte_dc,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic        o_px_valid,
  output logic [8:0]  o_px_x,
  output logic [8:0]  o_px_y,
  output logic [15:0] o_px_rgb,
  output logic [16:0] o_px_count
);

  localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
  localparam logic [9:0] HEIGHT_L = 10'(HEIGHT);
  localparam logic [8:0] EC_RST   = 9'(WIDTH - 1);
  localparam logic [8:0] EP_RST   = 9'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    PASET,
    RAMWR_HI,
    RAMWR_LO,
    SKIP
  } state_t;

  // Pixel is inside the panel
  function automatic logic in_bounds(input logic [8:0] x, input logic [8:0] y);
    return ({1'b0, x} < WIDTH_L) && ({1'b0, y} < HEIGHT_L);
  endfunction

  // Raster advance inside the window; returns {y_next, x_next}, 9-bit wrap
  function automatic logic [17:0] next_xy(input logic [8:0] x,  input logic [8:0] y,
                                          input logic [8:0] sc, input logic [8:0] ec,
                                          input logic [8:0] sp, input logic [8:0] ep);
    logic [8:0] xn;
    logic [8:0] yn;
    if (x == ec) begin
      xn = sc;
      yn = (y == ep) ? sp : y + 9'd1;
    end else begin
      xn = x + 9'd1;
      yn = y;
    end
    return {yn, xn};
  endfunction

  // Internal active-low reset: asserts with i_rst, releases two clocks later
  logic rst_sync_p0, rst_sync_p1;
  logic w_rst;

  // Reset release synchronizer
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
    end
  end

  assign w_rst = rst_sync_p1;

  // ---- stage p0/p1: input synchronizers, p2: SCLK edge reference ----
  logic sclk_p0, sclk_p1, sclk_p2;
  logic mosi_p0, mosi_p1;
  logic cs_p0, cs_p1;
  logic dc_p0, dc_p1;
  logic sclk_rise;

  // Two-flop synchronizers for all SPI pins plus the SCLK history flop
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
      cs_p0   <= 1'b0;
      cs_p1   <= 1'b0;
      dc_p0   <= 1'b0;
      dc_p1   <= 1'b0;
    end else begin
      sclk_p0 <= i_sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= i_mosi;
      mosi_p1 <= mosi_p0;
      cs_p0   <= i_cs;
      cs_p1   <= cs_p0;
      dc_p0   <= i_dc;
      dc_p1   <= dc_p0;
    end
  end

  assign sclk_rise = sclk_p1 & ~sclk_p2;

  // ---- stage p2: bit shifter and byte assembly ----
  logic [7:0] shift_p2;
  logic [2:0] bit_cnt;
  logic [7:0] byte_p2;
  logic       dc_p2;
  logic       vld_p2;

  // Shift MOSI on each SCLK rise while selected; CS high drops any partial byte
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst) begin
      shift_p2 <= '0;
      bit_cnt  <= '0;
      byte_p2  <= '0;
      dc_p2    <= 1'b0;
      vld_p2   <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      if (cs_p1) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_p2 <= {shift_p2[6:0], mosi_p1};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_p2 <= {shift_p2[6:0], mosi_p1};
          dc_p2   <= dc_p1;
          vld_p2  <= 1'b1;
        end
      end
    end
  end

  // ---- stage p3: byte output register ----
  // Present the completed byte with its DC flag as a one-cycle strobe
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst) begin
      o_byte_valid <= 1'b0;
      o_byte       <= '0;
      o_byte_dc    <= 1'b0;
    end else begin
      o_byte_valid <= vld_p2;
      if (vld_p2) begin
        o_byte    <= byte_p2;
        o_byte_dc <= dc_p2;
      end
    end
  end

  // ---- stage p4: command decoder ----
  state_t     state, state_nx;
  logic [1:0] par_idx;
  logic       par_hi;
  logic [8:0] par_start;
  logic [8:0] sc, ec, sp, ep;
  logic [8:0] cur_x, cur_y;
  logic [7:0] px_hi;

  // Decoder state register
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: commands always redirect, data bytes walk the current command
  always_comb begin
    state_nx = state;
    if (o_byte_valid) begin
      if (!o_byte_dc) begin
        case (o_byte)
          8'h2A:   state_nx = CASET;
          8'h2B:   state_nx = PASET;
          8'h2C:   state_nx = RAMWR_HI;
          default: state_nx = SKIP;
        endcase
      end else begin
        case (state)
          CASET, PASET: if (par_idx == 2'd3) state_nx = IDLE;
          RAMWR_HI:     state_nx = RAMWR_LO;
          RAMWR_LO:     state_nx = RAMWR_HI;
          default:      state_nx = state;
        endcase
      end
    end
  end

  // Window parameters, raster position and command/pixel output strobes
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst) begin
      o_cmd_valid <= 1'b0;
      o_cmd       <= '0;
      o_px_valid  <= 1'b0;
      o_px_x      <= '0;
      o_px_y      <= '0;
      o_px_rgb    <= '0;
      par_idx     <= '0;
      par_hi      <= 1'b0;
      par_start   <= '0;
      sc          <= '0;
      ec          <= EC_RST;
      sp          <= '0;
      ep          <= EP_RST;
      cur_x       <= '0;
      cur_y       <= '0;
      px_hi       <= '0;
    end else begin
      o_cmd_valid <= 1'b0;
      o_px_valid  <= 1'b0;
      if (o_byte_valid) begin
        if (!o_byte_dc) begin
          o_cmd_valid <= 1'b1;
          o_cmd       <= o_byte;
          par_idx     <= '0;
          if (o_byte == 8'h2C) begin
            cur_x <= sc;
            cur_y <= sp;
          end
        end else begin
          case (state)
            CASET, PASET: begin
              par_idx <= par_idx + 2'd1;
              case (par_idx)
                2'd0: par_hi    <= o_byte[0];
                2'd1: par_start <= {par_hi, o_byte};
                2'd2: par_hi    <= o_byte[0];
                default: begin
                  if (state == CASET) begin
                    sc <= par_start;
                    ec <= {par_hi, o_byte};
                  end else begin
                    sp <= par_start;
                    ep <= {par_hi, o_byte};
                  end
                end
              endcase
            end
            RAMWR_HI: px_hi <= o_byte;
            RAMWR_LO: begin
              if (in_bounds(cur_x, cur_y)) begin
                o_px_valid <= 1'b1;
                o_px_x     <= cur_x;
                o_px_y     <= cur_y;
                o_px_rgb   <= {px_hi, o_byte};
              end
              {cur_y, cur_x} <= next_xy(cur_x, cur_y, sc, ec, sp, ep);
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef SPI_LCD_RX_PXCOUNT_EN
  logic [16:0] px_cnt;

  // Saturating count of emitted pixels
  always_ff @(posedge i_clk or negedge w_rst) begin
    if (!w_rst)                         px_cnt <= '0;
    else if (o_px_valid && px_cnt != '1) px_cnt <= px_cnt + 17'd1;
  end

  assign o_px_count = px_cnt;
`else
  assign o_px_count = '0;
`endif

endmodule
